// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling and 3-sample majority vote, feeding a small
// valid/ready FIFO; sticky parity, framing and overrun flags.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick16,
    input  logic [1:0] cfg_len,
    input  logic       cfg_par_en,
    input  logic       cfg_par_even,
    input  logic       cfg_stop2,
    input  logic       rx_sn,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       rx_busy,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overrun,
    input  logic       err_clr
);

    localparam int unsigned CW       = 4;
    localparam int unsigned DW       = 8;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HI
    } state_t;

    typedef struct packed {
        logic [1:0] len;
        logic       par_en;
        logic       par_even;
        logic       stop2;
    } frame_cfg_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      samp_q, samp_d;
    logic            perr_q, perr_d;
    logic            stop2nd_q, stop2nd_d;
    frame_cfg_t      cfg_q, cfg_d;

    logic            rx_meta, rx_s;
    logic            vote_c;
    logic [2:0]      last_idx_c;
    logic            push_c, set_perr_c, set_ferr_c;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            full_c, pop_c, do_push_c, overrun_c;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_sn;
            rx_s    <= rx_meta;
        end
    end

    assign vote_c     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign last_idx_c = 3'(3'd4 + 3'(cfg_q.len));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            samp_q    <= '0;
            perr_q    <= 1'b0;
            stop2nd_q <= 1'b0;
            cfg_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            samp_q    <= samp_d;
            perr_q    <= perr_d;
            stop2nd_q <= stop2nd_d;
            cfg_q     <= cfg_d;
        end
    end

    // Next-state and frame datapath; decisions at cnt 9 (vote) and cnt 15 (bit end)
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        samp_d     = samp_q;
        perr_d     = perr_q;
        stop2nd_d  = stop2nd_q;
        cfg_d      = cfg_q;
        push_c     = 1'b0;
        set_perr_c = 1'b0;
        set_ferr_c = 1'b0;

        if (tick16 && state_q != S_IDLE && state_q != S_WAIT_HI) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) samp_d[0] = rx_s;
            if (cnt_q == 4'd8) samp_d[1] = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    data_d    = '0;
                    perr_d    = 1'b0;
                    stop2nd_d = 1'b0;
                    cfg_d     = '{len: cfg_len, par_en: cfg_par_en,
                                  par_even: cfg_par_even, stop2: cfg_stop2};
                end
            end
            S_START: begin
                if (tick16) begin
                    if (cnt_q == 4'd9 && vote_c) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == 4'd15) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick16) begin
                    if (cnt_q == 4'd9) data_d[bit_idx_q] = vote_c;
                    if (cnt_q == 4'd15) begin
                        if (bit_idx_q == last_idx_c) begin
                            state_d = cfg_q.par_en ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (tick16) begin
                    if (cnt_q == 4'd9) perr_d = vote_c ^ (^data_q) ^ ~cfg_q.par_even;
                    if (cnt_q == 4'd15) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick16) begin
                    if (cnt_q == 4'd9) begin
                        if (!vote_c) begin
                            set_ferr_c = 1'b1;
                            state_d    = S_WAIT_HI;
                        end else if (!(cfg_q.stop2 && !stop2nd_q)) begin
                            // Frame ends mid-stop so the next start edge is never missed
                            push_c     = ~perr_q;
                            set_perr_c = perr_q;
                            state_d    = S_IDLE;
                            cnt_d      = '0;
                        end
                    end else if (cnt_q == 4'd15) begin
                        stop2nd_d = 1'b1;
                    end
                end
            end
            S_WAIT_HI: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign full_c    = (count_q == FULL_CNT);
    assign pop_c     = rd_valid & rd_ready;
    assign do_push_c = push_c & (~full_c | pop_c);
    assign overrun_c = push_c & full_c & ~pop_c;

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr_q] <= data_q;
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push_c && !pop_c)      count_q <= count_q + (AW + 1)'(1);
            else if (pop_c && !do_push_c) count_q <= count_q - (AW + 1)'(1);
        end
    end

    // Sticky flags: a new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_parity  <= set_perr_c | (err_parity  & ~err_clr);
            err_frame   <= set_ferr_c | (err_frame   & ~err_clr);
            err_overrun <= overrun_c  | (err_overrun & ~err_clr);
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
    assign rx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, good words queued as
// expectations and compared as the FIFO hands them out.
module tb_uart_rx_fifo;

    localparam int DEPTH    = 4;
    localparam int TDIV     = 4;
    localparam int BIT_CLKS = 16 * TDIV;

    logic       clk;
    logic       rst;
    logic       tick16;
    logic [1:0] cfg_len;
    logic       cfg_par_en;
    logic       cfg_par_even;
    logic       cfg_stop2;
    logic       rx_sn;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       rx_busy;
    logic       err_parity;
    logic       err_frame;
    logic       err_overrun;
    logic       err_clr;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovr;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick16       (tick16),
        .cfg_len      (cfg_len),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_even (cfg_par_even),
        .cfg_stop2    (cfg_stop2),
        .rx_sn        (rx_sn),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rx_busy      (rx_busy),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_overrun  (err_overrun),
        .err_clr      (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick16 = 1'b0;
        forever begin
            repeat (TDIV - 1) @(negedge clk);
            tick16 = 1'b1;
            @(negedge clk);
            tick16 = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit par_of(input logic [7:0] d, input int nbits, input bit even);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        return even ? bit'(ones % 2) : bit'(1 - (ones % 2));
    endfunction

    task automatic drive_bit(input bit b);
        rx_sn = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input bit par_bit, input int nstop, input bit last_stop);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        for (int i = 0; i < nstop; i++) drive_bit((i == nstop - 1) ? last_stop : 1'b1);
    endtask

    // Consumer is held off while sending, so queue depth mirrors FIFO occupancy
    task automatic send_good(input logic [7:0] d, input int nbits, input bit has_par,
                             input bit par_bit, input int nstop);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovr = 1'b1;
        send_frame(d, nbits, has_par, par_bit, nstop, 1'b1);
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !rd_valid) break;
            @(negedge clk);
        end
        check_eq("drain_left", exp_q.size(), 0);
        check_eq("drain_valid", rd_valid, 1'b0);
        rd_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard pop: a word leaves the FIFO on the edge after valid&ready is seen
    always begin
        @(negedge clk);
        #1;
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check_eq("spurious_word", rd_data, 32'hFFFF_FFFF);
            else check_eq("rd_data", rd_data, exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; rx_sn = 1'b1; rd_ready = 1'b0; err_clr = 1'b0; exp_ovr = 1'b0;
        cfg_len = 2'd3; cfg_par_en = 1'b0; cfg_par_even = 1'b0; cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", rd_valid, 1'b0);
        check_eq("rst_data", rd_data, 8'h00);
        check_eq("rst_busy", rx_busy, 1'b0);
        check_eq("rst_errs", {err_parity, err_frame, err_overrun}, 3'b000);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1
        send_good(8'hA5, 8, 1'b0, 1'b0, 1);
        repeat (2) @(negedge clk);
        check_eq("8n1_valid", rd_valid, 1'b1);
        check_eq("8n1_busy", rx_busy, 1'b0);
        check_eq("8n1_errs", {err_parity, err_frame, err_overrun}, 3'b000);
        drain();

        // 7E1: wrong parity dropped, then correct parity accepted
        cfg_len = 2'd2; cfg_par_en = 1'b1; cfg_par_even = 1'b1;
        send_frame(8'h35, 7, 1'b1, ~par_of(8'h35, 7, 1'b1), 1, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("7e1_perr", err_parity, 1'b1);
        check_eq("7e1_perr_nopush", rd_valid, 1'b0);
        clear_flags();
        check_eq("7e1_perr_clr", err_parity, 1'b0);
        send_good(8'h35, 7, 1'b1, par_of(8'h35, 7, 1'b1), 1);
        repeat (2) @(negedge clk);
        check_eq("7e1_valid", rd_valid, 1'b1);
        check_eq("7e1_perr_ok", err_parity, 1'b0);
        drain();

        // 5O2: two good words, then second stop bit low
        cfg_len = 2'd0; cfg_par_even = 1'b0; cfg_stop2 = 1'b1;
        send_good(8'h1F, 5, 1'b1, par_of(8'h1F, 5, 1'b0), 2);
        send_good(8'h00, 5, 1'b1, par_of(8'h00, 5, 1'b0), 2);
        check_eq("5o2_errs", {err_parity, err_frame, err_overrun}, 3'b000);
        drain();
        send_frame(8'h0A, 5, 1'b1, par_of(8'h0A, 5, 1'b0), 2, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("5o2_ferr", err_frame, 1'b1);
        check_eq("5o2_wait_hi", rx_busy, 1'b1);
        check_eq("5o2_nopush", rd_valid, 1'b0);
        rx_sn = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("5o2_idle", rx_busy, 1'b0);
        clear_flags();
        check_eq("5o2_ferr_clr", err_frame, 1'b0);

        // Glitch shorter than the sample window
        cfg_len = 2'd3; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
        rx_sn = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("glitch_busy", rx_busy, 1'b1);
        repeat (4 * TDIV - 8) @(negedge clk);
        rx_sn = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_eq("glitch_idle", rx_busy, 1'b0);
        check_eq("glitch_nopush", rd_valid, 1'b0);
        check_eq("glitch_errs", {err_parity, err_frame, err_overrun}, 3'b000);

        // Overrun: five words into a four-deep FIFO
        exp_ovr = 1'b0;
        for (int v = 1; v <= 5; v++) send_good(8'(v), 8, 1'b0, 1'b0, 1);
        check_eq("ovr_flag", err_overrun, exp_ovr);
        check_eq("ovr_valid", rd_valid, 1'b1);
        drain();
        clear_flags();
        check_eq("ovr_clr", err_overrun, 1'b0);

        // Break: line held low for 20 bit times
        rx_sn = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check_eq("brk_ferr", err_frame, 1'b1);
        check_eq("brk_busy", rx_busy, 1'b1);
        check_eq("brk_nopush", rd_valid, 1'b0);
        rx_sn = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("brk_idle", rx_busy, 1'b0);

        // Reset mid-frame flushes FIFO and flags; this word is never read
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
        check_eq("pre_rst_valid", rd_valid, 1'b1);
        rx_sn = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check_eq("pre_rst_busy", rx_busy, 1'b1);
        rst = 1'b1;
        rx_sn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_out", {rd_data, rd_valid, rx_busy, err_parity, err_frame, err_overrun},
                 13'h0);
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        check_eq("post_rst_out", {rd_data, rd_valid, rx_busy, err_parity, err_frame, err_overrun},
                 13'h0);
        check_eq("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
